// File: rtl/systolic_pq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : systolic_pq_pkg
// Purpose  : Shared types and sentinel helpers for the systolic priority queue
// Revision : 1.0 - initial release
// ============================================================================
package systolic_pq_pkg;

  // Widest {key,value} word the sentinel helpers can build.
  localparam int PQ_WORD_MAX = 64;

  typedef logic [PQ_WORD_MAX-1:0] pq_word_t;

  // Operation performed by the head node in a given cycle.
  typedef enum logic [1:0] {
    PQ_IDLE    = 2'd0,
    PQ_INSERT  = 2'd1,
    PQ_EXTRACT = 2'd2,
    PQ_REPLACE = 2'd3
  } pq_op_t;

  // All-ones word of width w, zero above bit w-1.
  function automatic pq_word_t pq_ones(input int w);
    pq_word_t r;
    r = '0;
    for (int i = 0; i < PQ_WORD_MAX; i++) begin
      if (i < w) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Word that loses every comparison: the "empty slot" filler.
  function automatic pq_word_t pq_worst(input bit max_mode, input int w);
    return max_mode ? '0 : pq_ones(w);
  endfunction

  // Word that wins every comparison: the "nothing new" filler.
  function automatic pq_word_t pq_best(input bit max_mode, input int w);
    return max_mode ? pq_ones(w) : '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_pq_head_if.sv
`default_nettype none
// ============================================================================
// Module   : systolic_pq_head_if
// Purpose  : Insert/extract handshake bundle between a client and the head node
// Revision : 1.0 - initial release
// ============================================================================
interface systolic_pq_head_if #(
  parameter int KW = 8,
  parameter int VW = 4
);
  logic              ivalid;
  logic [KW+VW-1:0]  idata;
  logic              irdy;
  logic              ovalid;
  logic [KW+VW-1:0]  odata;
  logic              ordy;

  // Client side: offers inserts, takes extracted heads.
  modport master (
    output ivalid, idata, ordy,
    input  irdy, ovalid, odata
  );

  // Queue side: accepts inserts, presents the current head.
  modport slave (
    input  ivalid, idata, ordy,
    output irdy, ovalid, odata
  );
endinterface
`default_nettype wire

// File: rtl/systolic_pq_phase.sv
`default_nettype none
// ============================================================================
// Module   : systolic_pq_phase
// Purpose  : Odd/even phase generator shared by every node of the array
// Revision : 1.0 - initial release
// ============================================================================
module systolic_pq_phase (
  input  wire logic clk,
  input  wire logic rst,
  output logic      odd_o,
  output logic      even_o
);

  logic odd_q;

  // Phase flips every cycle; reset lands in odd=0 so the first cycle is even.
  always_ff @(posedge clk) begin
    if (rst) odd_q <= 1'b0;
    else     odd_q <= ~odd_q;
  end

  assign odd_o  = odd_q;
  assign even_o = ~odd_q;

endmodule
`default_nettype wire

// File: rtl/systolic_pq_head.sv
`default_nettype none
// ============================================================================
// Module   : systolic_pq_head
// Purpose  : Node 0 of the systolic priority queue: phase, handshakes,
//            operation decode, a/b stream injection, occupancy and high-water
// Revision : 1.0 - initial release
// ============================================================================
module systolic_pq_head
  import systolic_pq_pkg::*;
#(
  parameter int KW         = 8,
  parameter int VW         = 4,
  parameter int CAPACITY   = 4,
  parameter int MAX_MODE   = 0,
  parameter int REPLACE_EN = 1
) (
  input  wire logic                              clk,
  input  wire logic                              rst,
  systolic_pq_head_if.slave                      pq,
  input  wire logic [KW+VW-1:0]                  ai,
  output logic      [KW+VW-1:0]                  bo,
  output logic      [KW+VW-1:0]                  ao,
  output logic                                   even,
  output logic                                   odd,
  output logic      [$clog2(CAPACITY+1)-1:0]     count,
  output logic                                   full,
  output logic                                   empty,
  output logic      [$clog2(CAPACITY+1)-1:0]     hwm
);

  localparam int       W      = KW + VW;
  localparam int       CW     = $clog2(CAPACITY + 1);
  localparam bit       REP    = (REPLACE_EN != 0);
  localparam pq_word_t WORST_W = pq_worst(MAX_MODE != 0, W);
  localparam pq_word_t BEST_W  = pq_best(MAX_MODE != 0, W);
  localparam logic [W-1:0]  WORST = WORST_W[W-1:0];
  localparam logic [W-1:0]  BEST  = BEST_W[W-1:0];
  localparam logic [CW-1:0] CAP   = CW'(CAPACITY);
  localparam logic [CW-1:0] ONE   = CW'(1);

  logic          phase_even;
  logic          phase_odd;
  logic          full_w;
  logic          empty_w;
  logic          ovalid_w;
  logic          irdy_w;
  logic          ext_fire;
  logic          ins_fire;
  pq_op_t        op;

  logic [W-1:0]  bo_q, bo_d;
  logic [W-1:0]  ao_q, ao_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] hwm_q, hwm_d;

  systolic_pq_phase u_phase (
    .clk    (clk),
    .rst    (rst),
    .odd_o  (phase_odd),
    .even_o (phase_even)
  );

  assign full_w   = (count_q == CAP);
  assign empty_w  = (count_q == '0);
  assign ovalid_w = phase_even && !empty_w;
  assign ext_fire = ovalid_w && pq.ordy;

  // A full queue may still take an insert when it is paired with an extract
  // (replace); without replace support an extract shuts the insert side out.
  assign irdy_w   = phase_even
                  && (!full_w || (REP && ext_fire))
                  && !(!REP && ext_fire);
  assign ins_fire = pq.ivalid && irdy_w;

  // Decode the cycle's operation, replace taking priority over single ops.
  always_comb begin
    op = PQ_IDLE;
    if (ins_fire && ext_fire) op = PQ_REPLACE;
    else if (ext_fire)        op = PQ_EXTRACT;
    else if (ins_fire)        op = PQ_INSERT;
  end

  // Next stream words and occupancy for the decoded operation.
  always_comb begin
    bo_d    = WORST;
    ao_d    = BEST;
    count_d = count_q;
    unique case (op)
      PQ_REPLACE: begin
        bo_d = WORST;
        ao_d = pq.idata;
      end
      PQ_EXTRACT: begin
        bo_d    = WORST;
        ao_d    = WORST;
        count_d = count_q - ONE;
      end
      PQ_INSERT: begin
        bo_d    = pq.idata;
        ao_d    = BEST;
        count_d = count_q + ONE;
      end
      default: begin
        bo_d = WORST;
        ao_d = BEST;
      end
    endcase
  end

  // High-water mark tracks the occupancy that is about to be registered.
  always_comb begin
    hwm_d = (count_d > hwm_q) ? count_d : hwm_q;
  end

  // Output words, occupancy and high-water registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bo_q    <= WORST;
      ao_q    <= BEST;
      count_q <= '0;
      hwm_q   <= '0;
    end else begin
      bo_q    <= bo_d;
      ao_q    <= ao_d;
      count_q <= count_d;
      hwm_q   <= hwm_d;
    end
  end

  assign pq.irdy   = irdy_w;
  assign pq.ovalid = ovalid_w;
  assign pq.odata  = ai;

  assign bo    = bo_q;
  assign ao    = ao_q;
  assign even  = phase_even;
  assign odd   = phase_odd;
  assign count = count_q;
  assign full  = full_w;
  assign empty = empty_w;
  assign hwm   = hwm_q;

endmodule
`default_nettype wire

// File: tb/tb_systolic_pq_head.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_pq_head
// Purpose  : Directed self-checking bench for the priority-queue head node
//            (default config, no-replace config, max-mode config)
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_pq_head;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [11:0] ai_v = 12'h000;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  systolic_pq_head_if #(.KW(8), .VW(4)) bus_a ();
  systolic_pq_head_if #(.KW(8), .VW(4)) bus_n ();
  systolic_pq_head_if #(.KW(8), .VW(4)) bus_x ();

  logic [11:0] bo_a, ao_a, bo_n, ao_n, bo_x, ao_x;
  logic        even_a, odd_a, full_a, empty_a;
  logic        even_n, odd_n, full_n, empty_n;
  logic        even_x, odd_x, full_x, empty_x;
  logic [2:0]  count_a, hwm_a, count_n, hwm_n, count_x, hwm_x;

  // Default: min mode, replace enabled.
  systolic_pq_head #(.KW(8), .VW(4), .CAPACITY(4), .MAX_MODE(0), .REPLACE_EN(1)) dut (
    .clk(clk), .rst(rst), .pq(bus_a), .ai(ai_v), .bo(bo_a), .ao(ao_a),
    .even(even_a), .odd(odd_a), .count(count_a), .full(full_a), .empty(empty_a), .hwm(hwm_a)
  );

  // Replace disabled, fed the same stimulus as the default instance.
  systolic_pq_head #(.KW(8), .VW(4), .CAPACITY(4), .MAX_MODE(0), .REPLACE_EN(0)) dut_nr (
    .clk(clk), .rst(rst), .pq(bus_n), .ai(ai_v), .bo(bo_n), .ao(ao_n),
    .even(even_n), .odd(odd_n), .count(count_n), .full(full_n), .empty(empty_n), .hwm(hwm_n)
  );

  // Max mode, kept idle.
  systolic_pq_head #(.KW(8), .VW(4), .CAPACITY(4), .MAX_MODE(1), .REPLACE_EN(1)) dut_mx (
    .clk(clk), .rst(rst), .pq(bus_x), .ai(ai_v), .bo(bo_x), .ao(ao_x),
    .even(even_x), .odd(odd_x), .count(count_x), .full(full_x), .empty(empty_x), .hwm(hwm_x)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [11:0] id, input logic rd);
    bus_a.ivalid = iv; bus_a.idata = id; bus_a.ordy = rd;
    bus_n.ivalid = iv; bus_n.idata = id; bus_n.ordy = rd;
  endtask

  // Starts and ends in an even cycle; checks the default instance.
  task automatic do_insert(input logic [11:0] d, input logic [2:0] exp_cnt);
    drive(1'b1, d, 1'b0);
    #1;
    check_eq("ins_irdy", 32'(bus_a.irdy), 32'd1);
    tick();
    check_eq("ins_odd", 32'(odd_a), 32'd1);
    check_eq("ins_bo", 32'(bo_a), 32'(d));
    check_eq("ins_ao", 32'(ao_a), 32'h000);
    check_eq("ins_count", 32'(count_a), 32'(exp_cnt));
    drive(1'b0, 12'h000, 1'b0);
    tick();
    check_eq("idle_bo", 32'(bo_a), 32'hFFF);
  endtask

  initial begin
    drive(1'b0, 12'h000, 1'b0);
    bus_x.ivalid = 1'b0; bus_x.idata = 12'h000; bus_x.ordy = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state, first even cycle
    check_eq("rst_even", 32'(even_a), 32'd1);
    check_eq("rst_bo", 32'(bo_a), 32'hFFF);
    check_eq("rst_ao", 32'(ao_a), 32'h000);
    check_eq("rst_count", 32'(count_a), 32'd0);
    check_eq("rst_hwm", 32'(hwm_a), 32'd0);
    check_eq("rst_empty", 32'(empty_a), 32'd1);
    check_eq("rst_full", 32'(full_a), 32'd0);
    check_eq("rst_ovalid", 32'(bus_a.ovalid), 32'd0);
    check_eq("rst_irdy", 32'(bus_a.irdy), 32'd1);
    check_eq("mx_bo", 32'(bo_x), 32'h000);
    check_eq("mx_ao", 32'(ao_x), 32'hFFF);

    // Fill to capacity
    do_insert(12'h3A1, 3'd1);
    do_insert(12'h1B2, 3'd2);
    do_insert(12'h5C3, 3'd3);
    do_insert(12'h0D4, 3'd4);
    check_eq("fill_full", 32'(full_a), 32'd1);
    check_eq("fill_hwm", 32'(hwm_a), 32'd4);
    check_eq("fill_nr_count", 32'(count_n), 32'd4);

    // Fifth insert refused while full
    drive(1'b1, 12'h0E5, 1'b0);
    #1;
    check_eq("full_irdy", 32'(bus_a.irdy), 32'd0);
    tick();
    check_eq("full_count", 32'(count_a), 32'd4);
    check_eq("full_bo", 32'(bo_a), 32'hFFF);
    drive(1'b0, 12'h000, 1'b0);
    tick();

    // Extract from a full queue
    ai_v = 12'h0D4;
    drive(1'b0, 12'h000, 1'b1);
    #1;
    check_eq("ext_ovalid", 32'(bus_a.ovalid), 32'd1);
    check_eq("ext_odata", 32'(bus_a.odata), 32'h0D4);
    check_eq("ext_irdy", 32'(bus_a.irdy), 32'd1);
    check_eq("ext_nr_irdy", 32'(bus_n.irdy), 32'd0);
    tick();
    check_eq("ext_bo", 32'(bo_a), 32'hFFF);
    check_eq("ext_ao", 32'(ao_a), 32'hFFF);
    check_eq("ext_count", 32'(count_a), 32'd3);
    check_eq("ext_full", 32'(full_a), 32'd0);
    check_eq("ext_hwm", 32'(hwm_a), 32'd4);
    check_eq("ext_nr_count", 32'(count_n), 32'd3);
    // Odd cycle: no handshakes offered
    check_eq("odd_ovalid", 32'(bus_a.ovalid), 32'd0);
    check_eq("odd_irdy", 32'(bus_a.irdy), 32'd0);
    drive(1'b0, 12'h000, 1'b0);
    tick();

    // Refill, then simultaneous insert + extract
    do_insert(12'h1E0, 3'd4);
    check_eq("refill_nr_count", 32'(count_n), 32'd4);
    ai_v = 12'h1B2;
    drive(1'b1, 12'h222, 1'b1);
    #1;
    check_eq("rep_irdy", 32'(bus_a.irdy), 32'd1);
    check_eq("rep_nr_irdy", 32'(bus_n.irdy), 32'd0);
    tick();
    check_eq("rep_ao", 32'(ao_a), 32'h222);
    check_eq("rep_bo", 32'(bo_a), 32'hFFF);
    check_eq("rep_count", 32'(count_a), 32'd4);
    check_eq("rep_full", 32'(full_a), 32'd1);
    check_eq("nr_count", 32'(count_n), 32'd3);
    check_eq("nr_ao", 32'(ao_n), 32'hFFF);
    check_eq("nr_bo", 32'(bo_n), 32'hFFF);
    drive(1'b0, 12'h000, 1'b0);
    tick();

    // Mid-operation reset after three inserts
    rst = 1'b1;
    tick();
    rst = 1'b0;
    do_insert(12'h3A1, 3'd1);
    do_insert(12'h1B2, 3'd2);
    do_insert(12'h5C3, 3'd3);
    check_eq("pre_rst_hwm", 32'(hwm_a), 32'd3);
    rst = 1'b1;
    tick();
    check_eq("mid_rst_count", 32'(count_a), 32'd0);
    check_eq("mid_rst_hwm", 32'(hwm_a), 32'd0);
    check_eq("mid_rst_odd", 32'(odd_a), 32'd0);
    check_eq("mid_rst_bo", 32'(bo_a), 32'hFFF);
    check_eq("mid_rst_ao", 32'(ao_a), 32'h000);
    rst = 1'b0;

    // Extract attempt on empty queue
    drive(1'b0, 12'h000, 1'b1);
    #1;
    check_eq("empty_ovalid", 32'(bus_a.ovalid), 32'd0);
    tick();
    check_eq("empty_count", 32'(count_a), 32'd0);
    check_eq("empty_ao", 32'(ao_a), 32'h000);
    check_eq("empty_flag", 32'(empty_a), 32'd1);
    drive(1'b0, 12'h000, 1'b0);
    tick();

    // Max-mode instance stayed idle throughout
    check_eq("mx_idle_bo", 32'(bo_x), 32'h000);
    check_eq("mx_idle_ao", 32'(ao_x), 32'hFFF);
    check_eq("mx_count", 32'(count_x), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/systolic_pq_head.md
# systolic_pq_head

Parametrised head node (node 0) for the Leiserson systolic priority queue. It owns the odd/even phase, the external insert and extract handshakes, occupancy tracking, and the sentinel injection into node 1. Compared with the first-generation node 0, it adds:

- generic capacity with derived counter width;
- min/max ordering mode;
- a same-cycle replace operation;
- returned-head extraction;
- exact full/empty flags and a high-water mark.

## Interface
- KW, 8, key width (bits)
- VW, 4, value width (bits)
- CAPACITY, 4, number of elements the downstream array holds (≥1)
- MAX_MODE, 0, 0 = smallest key first; 1 = largest key first
- REPLACE_EN, 1, 1 = simultaneous insert+extract performed as one replace operation
- CW (localparam), $clog2(CAPACITY+1), counter width
- clk  in  1  single clock; all state on posedge
- rst  in  1  synchronous, active-high reset
- even  out  1  phase flag; !odd
- odd  out  1  phase flag; toggles every cycle
- ivalid  in  1  insert request
- idata  in  KW+VW  element {key,value}
- irdy  out  1  insert accepted when ivalid&&irdy
- ovalid  out  1  head element available
- odata  out  KW+VW  head element (= ai)
- ordy  in  1  extract accepted when ovalid&&ordy
- ai  in  KW+VW  current head held by node 1
- bo  out  KW+VW  b-stream word to node 1
- ao  out  KW+VW  a-stream word to node 1
- count  out  CW  occupancy
- full  out  1  count==CAPACITY
- empty  out  1  count==0
- hwm  out  CW  maximum count since reset

## Operation
- Sentinels (whole word, key and value):
  - MAX_MODE=0: WORST='1, BEST='0.
  - MAX_MODE=1: WORST='0, BEST='1.
- Phase: odd is a register toggling every cycle. even=!odd.
- Handshakes fire only in even cycles.
- ovalid = even && !empty. odata = ai, combinational pass-through.
- irdy = even && (!full || (REPLACE_EN && ovalid && ordy)) && !(!REPLACE_EN && ovalid && ordy).
  - With REPLACE_EN=0 an extract blocks a same-cycle insert.
  - irdy is combinationally dependent on ordy; upstream must not make ivalid depend on irdy.
- Operation decode per cycle, in priority order:
  - REPLACE: insert and extract both fire (REPLACE_EN=1) → bo<=WORST, ao<=idata, count unchanged.
  - EXTRACT: extract fires only → bo<=WORST, ao<=WORST, count-1.
  - INSERT: insert fires only → bo<=idata, ao<=BEST, count+1.
  - IDLE: all other cycles, including every odd cycle → bo<=WORST, ao<=BEST.
- hwm <= max(hwm, next count), evaluated every cycle.
- Count never wraps: insert is impossible when full (except replace), and extract is impossible when empty. The bench checks that count stays within 0..CAPACITY.

## Timing
- Reset values: odd=0 (so even=1 in the first cycle after reset), bo=WORST, ao=BEST, count=0, hwm=0, full=0, empty=1, ovalid=1&&!empty=0, irdy=1.
- bo/ao are registered. A word accepted in even cycle N is driven to node 1 during odd cycle N+1. Cycle N+2 is IDLE again unless a new handshake fires.
- After an insert into an empty queue, node 1 presents the element on ai at the earliest 2 cycles later. The head must not be extracted before ai settles. Node 1's spec guarantees ai is valid at every even cycle when !empty.
- count, full, empty and hwm update on the clock edge that ends the handshake cycle.
- rst asserted mid-operation aborts everything. In the next cycle all outputs take their reset values, and the downstream array sees BEST/WORST idle words. Node 1..N must be reset by the same rst.

## Structure
- Package systolic_pq_pkg contains:
  - typedef enum pq_op_t {PQ_IDLE, PQ_INSERT, PQ_EXTRACT, PQ_REPLACE};
  - functions pq_worst(max_mode, w) and pq_best(max_mode, w) returning sentinel words.
- Sub-module systolic_pq_phase generates odd/even. It is shared with the later processing nodes, which need the same phase.
- The head node contains the op decode, output registers, counter and hwm.

## Test plan
- Reset, KW=8, VW=4: even=1, bo=12'hFFF, ao=12'h000, count=0, empty=1, ovalid=0, irdy=1 in the first even cycle.
- Insert 12'h3A1, 12'h1B2, 12'h5C3, 12'h0D4 on successive even cycles (CAPACITY=4):
  - bo carries each word in the following odd cycle;
  - full=1 and hwm=4 after the 4th insert;
  - a 5th ivalid sees irdy=0.
- Full queue, ovalid&&ordy with ai=12'h0D4: odata=12'h0D4, bo=ao=12'hFFF next cycle, count=3, full=0.
- REPLACE_EN=1, count=4, ivalid with 12'h222 together with ordy: both fire, ao=12'h222, bo=12'hFFF, count stays 4.
- REPLACE_EN=0, same stimulus: irdy=0 and only the extract fires, count=3.
- MAX_MODE=1 idle: bo=12'h000, ao=12'hFFF.
- Assert rst after 3 inserts: the next cycle shows count=0, hwm=0, odd=0.
- An attempted extract when empty: ovalid=0 and count stays 0.
